// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between several
// req/gnt/rvalid masters, with a fixed-latency response and address-window checking.
module mem_port_arbiter #(
  parameter int                    NUM_MASTERS    = 2,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    MEM_ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE       = 32'h0010_0000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_MASTERS-1:0]              m_req_i,
  output logic [NUM_MASTERS-1:0]              m_gnt_o,
  output logic [NUM_MASTERS-1:0]              m_rvalid_o,
  output logic [NUM_MASTERS-1:0]              m_err_o,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr_i,
  input  logic [NUM_MASTERS-1:0]              m_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata_i,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_rdata_o,
  output logic                                mem_en_o,
  output logic [MEM_ADDR_WIDTH-1:0]           mem_addr_o,
  output logic                                mem_we_o,
  output logic [DATA_WIDTH/8-1:0]             mem_be_o,
  output logic [DATA_WIDTH-1:0]               mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]               mem_rdata_i
);

  localparam int                   BE_WIDTH  = DATA_WIDTH / 8;
  localparam int                   IDX_WIDTH = $clog2(NUM_MASTERS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_MASTERS - 1);

  logic [IDX_WIDTH-1:0]  prio_q, prio_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [IDX_WIDTH-1:0]  rsp_idx_q, rsp_idx_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_rd_q, rsp_rd_d;

  logic                  gnt_valid;
  logic [IDX_WIDTH-1:0]  gnt_idx;
  logic [IDX_WIDTH-1:0]  scan_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [BE_WIDTH-1:0]   sel_be;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  in_window;
  logic                  mem_en;

  // Scan upward from prio_q with an explicit wrap so non-power-of-2 counts work.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    scan_idx  = prio_q;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!gnt_valid && m_req_i[scan_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = scan_idx;
      end
      scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
    end
    if (rst) begin
      gnt_valid = 1'b0;
    end
  end

  // Idle cycles leave gnt_idx at 0, so the SRAM bus follows master 0 rather than floating.
  always_comb begin
    sel_addr  = m_addr_i[0 +: ADDR_WIDTH];
    sel_we    = m_we_i[0];
    sel_be    = m_be_i[0 +: BE_WIDTH];
    sel_wdata = m_wdata_i[0 +: DATA_WIDTH];
    for (int i = 1; i < NUM_MASTERS; i++) begin
      if (gnt_idx == IDX_WIDTH'(i)) begin
        sel_addr  = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_we    = m_we_i[i];
        sel_be    = m_be_i[i*BE_WIDTH +: BE_WIDTH];
        sel_wdata = m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign in_window   = (sel_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH] == MEM_BASE[ADDR_WIDTH-1:MEM_ADDR_WIDTH]);
  assign mem_en      = gnt_valid & in_window;
  assign mem_en_o    = mem_en;
  assign mem_we_o    = mem_en & sel_we;
  assign mem_be_o    = mem_en ? sel_be : '0;
  assign mem_addr_o  = sel_addr[MEM_ADDR_WIDTH-1:0];
  assign mem_wdata_o = sel_wdata;

  always_comb begin
    m_gnt_o = '0;
    if (gnt_valid) begin
      m_gnt_o[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    prio_d      = prio_q;
    rsp_valid_d = gnt_valid;
    rsp_idx_d   = gnt_idx;
    rsp_err_d   = gnt_valid & ~in_window;
    rsp_rd_d    = mem_en & ~sel_we;
    if (gnt_valid) begin
      prio_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rd_q    <= rsp_rd_d;
    end
  end

  // Only an in-window read returns SRAM data; writes and errors return zero.
  always_comb begin
    m_rvalid_o = '0;
    m_err_o    = '0;
    m_rdata_o  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (rsp_valid_q && (rsp_idx_q == IDX_WIDTH'(i))) begin
        m_rvalid_o[i] = 1'b1;
        m_err_o[i]    = rsp_err_q;
        if (rsp_rd_q) begin
          m_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = mem_rdata_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table on a 2-master instance,
// plus hand sequences for 3-master wrap-around and reset during a pending response.
module tb_mem_port_arbiter;

  // Vector record: inputs for one cycle, the expected combinational grant-side
  // outputs, and the expected response outputs for the grant of the previous cycle.
  typedef struct {
    logic [1:0]  req;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [1:0]  we;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [31:0] memRdata;
    logic [1:0]  gnt;
    logic        memEn;
    logic [15:0] memAddr;
    logic        memWe;
    logic [3:0]  memBe;
    logic [31:0] memWdata;
    logic [1:0]  rvalid;
    logic [1:0]  err;
    logic [63:0] rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic [1:0]  req, gnt, rvalid, err, we;
  logic [63:0] addr, wdata, rdata;
  logic [7:0]  be;
  logic        memEn, memWe;
  logic [15:0] memAddr;
  logic [3:0]  memBe;
  logic [31:0] memWdata, memRdata;

  logic [2:0]  req3, gnt3, rvalid3, err3;
  logic [95:0] addr3, wdata3, rdata3;
  logic [11:0] be3;
  logic        memEn3, memWe3;
  logic [15:0] memAddr3;
  logic [3:0]  memBe3;
  logic [31:0] memWdata3;

  int checks = 0;
  int fails  = 0;

  mem_port_arbiter #(.NUM_MASTERS(2)) u_dut (
    .clk(clk), .rst(rst),
    .m_req_i(req), .m_gnt_o(gnt), .m_rvalid_o(rvalid), .m_err_o(err),
    .m_addr_i(addr), .m_we_i(we), .m_be_i(be), .m_wdata_i(wdata), .m_rdata_o(rdata),
    .mem_en_o(memEn), .mem_addr_o(memAddr), .mem_we_o(memWe), .mem_be_o(memBe),
    .mem_wdata_o(memWdata), .mem_rdata_i(memRdata)
  );

  mem_port_arbiter #(.NUM_MASTERS(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .m_req_i(req3), .m_gnt_o(gnt3), .m_rvalid_o(rvalid3), .m_err_o(err3),
    .m_addr_i(addr3), .m_we_i(3'b000), .m_be_i(be3), .m_wdata_i(wdata3), .m_rdata_o(rdata3),
    .mem_en_o(memEn3), .mem_addr_o(memAddr3), .mem_we_o(memWe3), .mem_be_o(memBe3),
    .mem_wdata_o(memWdata3), .mem_rdata_i(32'h5555_AAAA)
  );

  // Every comparison funnels through here so the counters stay consistent.
  task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one vector's inputs onto the 2-master instance.
  task automatic applyStimulus(input vec_t v);
    req      = v.req;
    addr     = {v.addr1, v.addr0};
    we       = v.we;
    be       = v.be;
    wdata    = v.wdata;
    memRdata = v.memRdata;
  endtask

  vec_t vecs[13];
  logic [2:0] expGnt3[4];
  logic [2:0] expRv3[4];

  initial begin
    // req, addr0, addr1, we, be, wdata, memRdata | gnt, memEn, memAddr, memWe, memBe, memWdata | rvalid, err, rdata
    vecs[0]  = '{2'b01, 32'h0010_0040, 32'h0, 2'b00, 8'h0F, 64'h0, 32'h0,
                 2'b01, 1'b1, 16'h0040, 1'b0, 4'hF, 32'h0, 2'b00, 2'b00, 64'h0};
    vecs[1]  = '{2'b00, 32'h0, 32'h0, 2'b00, 8'h00, 64'h0, 32'hDEAD_BEEF,
                 2'b00, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0, 2'b01, 2'b00, 64'h0000_0000_DEAD_BEEF};
    vecs[2]  = '{2'b10, 32'h0, 32'h0010_FFFC, 2'b10, 8'h20, 64'h0000_AB00_0000_0000, 32'h0,
                 2'b10, 1'b1, 16'hFFFC, 1'b1, 4'b0010, 32'h0000_AB00, 2'b00, 2'b00, 64'h0};
    vecs[3]  = '{2'b11, 32'h0010_0100, 32'h0010_0200, 2'b00, 8'hFF, 64'h0, 32'h1234_5678,
                 2'b01, 1'b1, 16'h0100, 1'b0, 4'hF, 32'h0, 2'b10, 2'b00, 64'h0};
    vecs[4]  = '{2'b11, 32'h0010_0100, 32'h0010_0200, 2'b00, 8'hFF, 64'h0, 32'hA0A0_0001,
                 2'b10, 1'b1, 16'h0200, 1'b0, 4'hF, 32'h0, 2'b01, 2'b00, 64'h0000_0000_A0A0_0001};
    vecs[5]  = '{2'b11, 32'h0010_0100, 32'h0010_0200, 2'b00, 8'hFF, 64'h0, 32'hB0B0_0002,
                 2'b01, 1'b1, 16'h0100, 1'b0, 4'hF, 32'h0, 2'b10, 2'b00, 64'hB0B0_0002_0000_0000};
    vecs[6]  = '{2'b11, 32'h0010_0100, 32'h0010_0200, 2'b00, 8'hFF, 64'h0, 32'hC0C0_0003,
                 2'b10, 1'b1, 16'h0200, 1'b0, 4'hF, 32'h0, 2'b01, 2'b00, 64'h0000_0000_C0C0_0003};
    vecs[7]  = '{2'b01, 32'h0020_0000, 32'h0, 2'b00, 8'h0F, 64'h0, 32'hD0D0_0004,
                 2'b01, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0, 2'b10, 2'b00, 64'hD0D0_0004_0000_0000};
    vecs[8]  = '{2'b00, 32'h0, 32'h0, 2'b00, 8'h00, 64'h0, 32'hFFFF_FFFF,
                 2'b00, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0, 2'b01, 2'b01, 64'h0};
    vecs[9]  = '{2'b10, 32'h0, 32'h0010_0008, 2'b00, 8'hF0, 64'h0, 32'h0,
                 2'b10, 1'b1, 16'h0008, 1'b0, 4'hF, 32'h0, 2'b00, 2'b00, 64'h0};
    vecs[10] = '{2'b10, 32'h0, 32'h0011_0000, 2'b00, 8'hF0, 64'h0, 32'h1111_1111,
                 2'b10, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0, 2'b10, 2'b00, 64'h1111_1111_0000_0000};
    vecs[11] = '{2'b00, 32'h0, 32'h0, 2'b00, 8'h00, 64'h0, 32'h2222_2222,
                 2'b00, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0, 2'b10, 2'b10, 64'h0};
    vecs[12] = '{2'b00, 32'h0, 32'h0, 2'b00, 8'h00, 64'h0, 32'h3333_3333,
                 2'b00, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0, 2'b00, 2'b00, 64'h0};

    expGnt3 = '{3'b100, 3'b001, 3'b010, 3'b100};
    expRv3  = '{3'b010, 3'b100, 3'b001, 3'b010};

    // Reset with requests pending: every gated output must stay low.
    rst = 1'b1;
    applyStimulus(vecs[3]);
    req3 = 3'b111; addr3 = {3{32'h0010_0010}}; be3 = 12'hFFF; wdata3 = '0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    checkOutput("reset_gnt", gnt, 2'b00);
    checkOutput("reset_memEn", memEn, 1'b0);
    checkOutput("reset_rvalid", rvalid, 2'b00);
    checkOutput("reset_err", err, 2'b00);
    checkOutput("reset_rdata", rdata, 64'h0);
    checkOutput("reset_gnt3", gnt3, 3'b000);
    req3 = 3'b000;
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven run on the 2-master instance.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      #3;
      checkOutput($sformatf("v%0d_gnt", i), gnt, vecs[i].gnt);
      checkOutput($sformatf("v%0d_memEn", i), memEn, vecs[i].memEn);
      if (vecs[i].memEn || vecs[i].gnt == 2'b00) begin
        checkOutput($sformatf("v%0d_memWe", i), memWe, vecs[i].memWe);
        checkOutput($sformatf("v%0d_memBe", i), memBe, vecs[i].memBe);
      end
      if (vecs[i].memEn) begin
        checkOutput($sformatf("v%0d_memAddr", i), memAddr, vecs[i].memAddr);
        checkOutput($sformatf("v%0d_memWdata", i), memWdata, vecs[i].memWdata);
      end
      checkOutput($sformatf("v%0d_rvalid", i), rvalid, vecs[i].rvalid);
      checkOutput($sformatf("v%0d_err", i), err, vecs[i].err);
      checkOutput($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
      @(posedge clk); #1;
    end

    // 3 masters: move priority to 2 with a lone m1 grant, then all request.
    req3 = 3'b010;
    #3;
    checkOutput("m3_prep_gnt", gnt3, 3'b010);
    @(posedge clk); #1;
    req3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #3;
      checkOutput($sformatf("m3_wrap%0d_gnt", i), gnt3, expGnt3[i]);
      checkOutput($sformatf("m3_wrap%0d_rvalid", i), rvalid3, expRv3[i]);
      @(posedge clk); #1;
    end
    req3 = 3'b000;
    #3;
    checkOutput("m3_last_rvalid", rvalid3, 3'b100);
    checkOutput("m3_last_rdata", rdata3, {32'h5555_AAAA, 64'h0});
    checkOutput("m3_idle_gnt", gnt3, 3'b000);
    @(posedge clk); #1;

    // Reset while a response is visible: it must vanish and priority return to 0.
    req = 2'b01; addr = {32'h0, 32'h0010_0040}; we = 2'b00; be = 8'hFF; memRdata = 32'hCAFE_F00D;
    #3;
    checkOutput("rstmid_gnt", gnt, 2'b01);
    @(posedge clk); #1;
    req = 2'b00;
    checkOutput("rstmid_pre_rvalid", rvalid, 2'b01);
    rst = 1'b1;
    req = 2'b11; addr = {32'h0010_0200, 32'h0010_0100};
    #1;
    checkOutput("rstmid_rvalid_dropped", rvalid, 2'b00);
    checkOutput("rstmid_gnt_gated", gnt, 2'b00);
    checkOutput("rstmid_memEn_gated", memEn, 1'b0);
    @(posedge clk); #1;
    checkOutput("rstmid_rvalid_held", rvalid, 2'b00);
    rst = 1'b0;
    #2;
    checkOutput("rstmid_prio0_gnt", gnt, 2'b01);
    @(posedge clk); #1;
    req = 2'b00;
    #2;
    checkOutput("rstmid_after_rvalid", rvalid, 2'b01);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous SRAM port between NUM_MASTERS req/gnt/rvalid masters, e.g. master 0 = core LSU, master 1 = debug system-bus access.
- Sits between the bus interconnect and the data SRAM wrapper.
- Grants one request per cycle, round-robin.
- Returns the response to the issuing master exactly one cycle after the grant.
- Flags out-of-window addresses with an error response and does not touch the SRAM for them.

Parameters:
- NUM_MASTERS, 2, number of requesters (≥2).
- ADDR_WIDTH, 32, master byte-address width.
- DATA_WIDTH, 32, data width. BE width is DATA_WIDTH/8.
- MEM_ADDR_WIDTH, 16, SRAM byte-address width (window size = 2**MEM_ADDR_WIDTH bytes).
- MEM_BASE, 32'h0010_0000, window base address, aligned to the window size.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- m_req_i  in  NUM_MASTERS  per-master request.
- m_gnt_o  out  NUM_MASTERS  per-master grant, one-hot or zero.
- m_rvalid_o  out  NUM_MASTERS  per-master response valid.
- m_err_o  out  NUM_MASTERS  per-master error, qualified by rvalid.
- m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_we_i  in  NUM_MASTERS  write enable.
- m_be_i  in  NUM_MASTERS*DATA_WIDTH/8  byte enables.
- m_wdata_i  in  NUM_MASTERS*DATA_WIDTH  write data.
- m_rdata_o  out  NUM_MASTERS*DATA_WIDTH  read data, qualified by rvalid.
- mem_en_o  out  1  SRAM enable.
- mem_addr_o  out  MEM_ADDR_WIDTH  SRAM byte address (offset from MEM_BASE).
- mem_we_o  out  1  SRAM write enable.
- mem_be_o  out  DATA_WIDTH/8  SRAM byte enables.
- mem_wdata_o  out  DATA_WIDTH  SRAM write data.
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid the cycle after mem_en_o.

Behaviour:
- **Clocking and reset:** one clock, clk. Reset is asynchronous and active-high on rst.
- **Reset values:**
  - Registered state: prio_q = 0 (master 0 highest), rsp_valid_q = 0, rsp_idx_q = 0, rsp_err_q = 0.
  - Outputs while rst is high: m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o and mem_en_o all 0.
- **Protocol:**
  - A master holds req, addr, we, be and wdata stable from req rise until the cycle it sees gnt.
  - gnt is combinational, in the same cycle as req.
  - The master may raise a new req in the cycle after gnt (back-to-back allowed).
- **Arbitration:**
  - Each cycle, grant the first requesting master at or after prio_q, scanning upward and wrapping modulo NUM_MASTERS.
  - On a grant to index g, prio_q <= (g+1) mod NUM_MASTERS.
  - With no request, prio_q holds.
  - With a single requester, that master is granted every cycle.
- **Window decode:** granted request is in-window iff addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH] == MEM_BASE[ADDR_WIDTH-1:MEM_ADDR_WIDTH].
- **In-window grant:**
  - mem_en_o = 1 in the grant cycle.
  - mem_addr_o = addr[MEM_ADDR_WIDTH-1:0]; we, be and wdata are muxed from the granted master.
- **Out-of-window grant:** gnt is still given, mem_en_o = 0, and rsp_err_q <= 1.
- **Idle / non-granted drive:** when there is no grant, mem_en_o = 0, mem_we_o = 0 and mem_be_o = 0. mem_addr_o and mem_wdata_o are don't-care but driven from the lowest-index master, never X.
- **Response (latency 1):**
  - In the cycle after any grant: rsp_valid_q = 1, m_rvalid_o[rsp_idx_q] = 1, all other rvalid bits 0.
  - Read, in-window: m_rdata_o slice = mem_rdata_i.
  - Write, or any error: m_rdata_o slice = 0.
  - m_err_o[rsp_idx_q] = rsp_err_q.
  - Every non-responding rdata slice is 0.
- **Throughput:** one grant and one response per cycle sustained. A new grant may coincide with the previous response.
- **Reset mid-operation:** a pending response is dropped (rvalid not asserted after reset) and prio_q returns to 0.
- **Arithmetic:** prio_q is $clog2(NUM_MASTERS) bits. The wrap is an explicit compare to NUM_MASTERS-1, not a power-of-2 overflow.

Test Plan:
- **Reset mid-response:** assert rst in a cycle between grant and response → no rvalid after reset. Then m0_req → m0 granted (prio_q = 0).
- **Single read:** after reset, m0 reads 0x0010_0040 → same cycle gnt = 2'b01, mem_en = 1, mem_addr = 16'h0040. Next cycle m_rvalid_o = 2'b01, m0 rdata = mem_rdata_i (e.g. 32'hDEADBEEF), err = 0.
- **Simultaneous requests:** m0 and m1 both request continuously for 4 cycles → grants 01, 10, 01, 10. Each rvalid is one cycle after its grant, routed to the correct master.
- **Byte write:** m1 writes 0x0010_FFFC, be = 4'b0010, wdata = 32'h0000AB00 → mem_we = 1, mem_be = 4'b0010, mem_addr = 16'hFFFC. Next cycle m1 rvalid = 1, rdata = 0, err = 0.
- **Out-of-window:** m0 reads 0x0020_0000 → gnt = 1, mem_en = 0. Next cycle m0 rvalid = 1, err = 1, rdata = 0.
- **Wrap-around with 3 masters:** NUM_MASTERS = 3, all requesting, prio_q = 2 → grant order m2, m0, m1, m2.
